// File: rtl/led_matrix_scan_driver.sv
// Serial-loaded, double-buffered LED matrix column scanner with blanking.
// Define LED_MATRIX_PWM_EN to add the 4-bit brightness input and row PWM gating.

module led_matrix_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic lvl,
  output logic rise
);
  logic [2:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[1:0], pin};
  end

  assign lvl  = sr[1];
  assign rise = sr[1] & ~sr[2];
endmodule

module led_matrix_scan_driver #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int DWELL_BITS   = 5,
  parameter int BLANK_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            din,
  input  logic            dclk,
  input  logic            strobe,
  input  logic            en,
`ifdef LED_MATRIX_PWM_EN
  input  logic [3:0]      brightness,
`endif
  output logic [ROWS-1:0] row_out,
  output logic [COLS-1:0] col_sel,
  output logic            frame_start
);
  localparam int N  = ROWS * COLS;
  localparam int CW = $clog2(COLS);
  localparam logic [CW-1:0]         COL_LAST = CW'(COLS - 1);
  localparam logic [DWELL_BITS-1:0] BLANK_W  = DWELL_BITS'(BLANK_CYCLES);

  // pin index: 0 = din, 1 = dclk, 2 = strobe
  logic [2:0] pin_raw, pin_lvl, pin_rise;
  assign pin_raw = {strobe, dclk, din};

  for (genvar i = 0; i < 3; i++) begin : g_sync
    led_matrix_sync u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .pin  (pin_raw[i]),
      .lvl  (pin_lvl[i]),
      .rise (pin_rise[i])
    );
  end

  logic din_s, shift, stb;
  logic unused_sync;
  assign din_s       = pin_lvl[0];
  assign shift       = pin_rise[1];
  assign stb         = pin_rise[2];
  assign unused_sync = ^{pin_rise[0], pin_lvl[2:1]};

  logic [N-1:0]          chain, staging, vbuf, disp;
  logic                  pending, en_q, wrap_q;
  logic [DWELL_BITS-1:0] dwell;
  logic [CW-1:0]         col;
  logic                  wrap, resume, commit, drive, lit;
  logic [ROWS-1:0]       col_rows;

  // Resuming from en=0 is a commit point too; the display path reads staging
  // on that cycle so column 0 never shows the stale buffer.
  always_comb begin
    wrap     = en && (&dwell) && (col == COL_LAST);
    resume   = en && !en_q;
    commit   = pending && (wrap || resume);
    disp     = (resume && pending) ? staging : vbuf;
    drive    = en && (dwell >= BLANK_W);
    col_rows = disp[int'(col) * ROWS +: ROWS];
    lit      = drive;
`ifdef LED_MATRIX_PWM_EN
    lit      = drive && (dwell[DWELL_BITS-1 -: 4] < brightness);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain       <= '0;
      staging     <= '0;
      vbuf        <= '0;
      pending     <= 1'b0;
      en_q        <= 1'b0;
      wrap_q      <= 1'b0;
      dwell       <= '0;
      col         <= '0;
      row_out     <= '0;
      col_sel     <= '0;
      frame_start <= 1'b0;
    end else begin
      if (shift) chain <= {chain[N-2:0], din_s};
      // staging takes the pre-shift chain when both edges coincide
      if (stb) staging <= chain;
      if (commit) vbuf <= staging;
      if (stb)         pending <= 1'b1;
      else if (commit) pending <= 1'b0;

      en_q   <= en;
      wrap_q <= wrap;

      if (!en) begin
        dwell <= '0;
        col   <= '0;
      end else begin
        dwell <= dwell + 1'b1;
        if (&dwell) col <= (col == COL_LAST) ? '0 : col + 1'b1;
      end

      col_sel     <= drive ? (COLS'(1) << col) : '0;
      row_out     <= lit ? col_rows : '0;
      frame_start <= en && wrap_q;
    end
  end
endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Directed bench for led_matrix_scan_driver at default parameters (8x8, 32-cycle dwell, 2 blank).
module tb_led_matrix_scan_driver;
  logic       clk = 1'b0, rst_n = 1'b0, din = 1'b0, dclk = 1'b0, strobe = 1'b0, en = 1'b0;
  logic [7:0] row_out, col_sel;
  logic       frame_start;
`ifdef LED_MATRIX_PWM_EN
  logic [3:0] brightness = 4'd15;
`endif

  int total = 0, bad = 0;

  localparam logic [63:0] IMG1 = 64'h00000000A5000000;
  localparam logic [63:0] IMG2 = 64'h0123456789ABCDEF;
  localparam logic [63:0] IMG3 = 64'h02468ACF13579BDE;
  localparam logic [63:0] IMG4 = 64'h048D159E26AF37BD;

  always #5 clk = ~clk;

  led_matrix_scan_driver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .dclk       (dclk),
    .strobe     (strobe),
    .en         (en),
`ifdef LED_MATRIX_PWM_EN
    .brightness (brightness),
`endif
    .row_out    (row_out),
    .col_sel    (col_sel),
    .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 1 when the current outputs disagree with what image img should show
  function automatic int disp_bad(input logic [63:0] img);
    int c;
    logic [7:0] e;
    c = 0;
    if (col_sel == 8'h00) return int'(row_out != 8'h00);
    if (!$onehot(col_sel)) return 1;
    for (int k = 0; k < 8; k++) if (col_sel[k]) c = k;
    e = img[c*8 +: 8];
`ifdef LED_MATRIX_PWM_EN
    if (row_out == 8'h00) return 0;
`endif
    return int'(row_out != e);
  endfunction

  task automatic shift_bit(input logic b);
    din = b; cycles(3);
    dclk = 1'b1; cycles(3);
    dclk = 1'b0; cycles(3);
  endtask

  task automatic load(input logic [63:0] img);
    for (int i = 63; i >= 0; i--) shift_bit(img[i]);
  endtask

  task automatic pulse_strobe;
    strobe = 1'b1; cycles(3);
    strobe = 1'b0; cycles(3);
  endtask

  task automatic wait_fs(input logic [63:0] img, input bit use_img, input string tag);
    int n, nb;
    n = 0; nb = 0;
    while (frame_start !== 1'b1 && n < 600) begin
      if (use_img) nb += disp_bad(img);
      @(negedge clk);
      n++;
    end
    chk({tag, "_fs"}, 64'(frame_start), 64'd1);
    if (use_img) chk({tag, "_old"}, 64'(nb), 64'd0);
  endtask

  // Starts on a frame_start cycle and checks exactly one frame.
  task automatic observe_frame(input logic [63:0] img, input string tag, output logic [7:0] c3);
    int nb, nd, nfs;
    nb = 0; nd = 0; nfs = 0; c3 = 8'h00;
    for (int i = 0; i < 256; i++) begin
      nb += disp_bad(img);
      if (col_sel != 8'h00) nd++;
      if (i > 0 && frame_start) nfs++;
      if (col_sel == 8'h08) c3 = row_out;
      @(negedge clk);
    end
    chk({tag, "_pix"}, 64'(nb), 64'd0);
    chk({tag, "_drv"}, 64'(nd), 64'd240);
    chk({tag, "_fs_extra"}, 64'(nfs), 64'd0);
  endtask

  initial begin
    int first_col, first_fs, n, nb, nd, nfs;
    logic [7:0] c3;

    // reset
    en = 1'b1; rst_n = 1'b0;
    cycles(4);
    chk("rst_row", 64'(row_out), 64'd0);
    chk("rst_col", 64'(col_sel), 64'd0);
    chk("rst_fs", 64'(frame_start), 64'd0);
    rst_n = 1'b1;
    first_col = 0; first_fs = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (first_col == 0 && col_sel == 8'h01) first_col = c;
      if (first_fs == 0 && frame_start) first_fs = c;
    end
    chk("first_col", 64'(first_col), 64'd3);
    chk("first_fs", 64'(first_fs), 64'd257);

    // load and commit
    load(IMG1);
    pulse_strobe();
    wait_fs(64'd0, 1'b0, "t2");
    observe_frame(IMG1, "t2", c3);
    chk("t2_col3", 64'(c3), 64'hA5);

    // deferred commit: strobe while column 5 is on
    load(IMG2);
    n = 0;
    while (col_sel !== 8'h20 && n < 600) begin @(negedge clk); n++; end
    chk("t3_col5", 64'(col_sel), 64'h20);
    pulse_strobe();
    wait_fs(IMG1, 1'b1, "t3");
    observe_frame(IMG2, "t3", c3);

    // simultaneous shift and strobe: staging sees the pre-shift chain
    shift_bit(1'b0);
    din = 1'b1; cycles(3);
    dclk = 1'b1; strobe = 1'b1; cycles(3);
    dclk = 1'b0; strobe = 1'b0; cycles(3);
    wait_fs(64'd0, 1'b0, "t4");
    observe_frame(IMG3, "t4", c3);

    // enable gating with a strobe while idle
    en = 1'b0;
    nb = 0; nfs = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 10) strobe = 1'b1;
      if (i == 14) strobe = 1'b0;
      @(negedge clk);
      if (row_out != 8'h00 || col_sel != 8'h00) nb++;
      if (frame_start) nfs++;
    end
    chk("t5_idle_out", 64'(nb), 64'd0);
    chk("t5_idle_fs", 64'(nfs), 64'd0);
    en = 1'b1;
    nb = 0; nd = 0; nfs = 0;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      nb += disp_bad(IMG4);
      if (col_sel != 8'h00) nd++;
      if (frame_start) nfs++;
    end
    chk("t5_pix", 64'(nb), 64'd0);
    chk("t5_drv", 64'(nd), 64'd240);
    chk("t5_fs_early", 64'(nfs), 64'd0);
    @(negedge clk);
    chk("t5_fs", 64'(frame_start), 64'd1);

`ifdef LED_MATRIX_PWM_EN
    // brightness 4: only dwell 2..7 of each column lit
    brightness = 4'd4;
    wait_fs(64'd0, 1'b0, "pwm4");
    n = 0;
    for (int i = 0; i < 256; i++) begin
      if (row_out != 8'h00) n++;
      @(negedge clk);
    end
    chk("pwm4_lit", 64'(n), 64'd48);
    brightness = 4'd0;
    n = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (row_out != 8'h00) n++;
    end
    chk("pwm0_lit", 64'(n), 64'd0);
    brightness = 4'd15;
`endif

    // mid-frame reset clears the frame buffer and restarts the scan
    cycles(100);
    rst_n = 1'b0;
    cycles(2);
    chk("t6_rst_row", 64'(row_out), 64'd0);
    chk("t6_rst_col", 64'(col_sel), 64'd0);
    rst_n = 1'b1;
    first_col = 0; nb = 0; nd = 0;
    for (int c = 1; c <= 256; c++) begin
      @(negedge clk);
      if (first_col == 0 && col_sel == 8'h01) first_col = c;
      nb += disp_bad(64'd0);
      if (col_sel != 8'h00) nd++;
    end
    chk("t6_first_col", 64'(first_col), 64'd3);
    chk("t6_pix", 64'(nb), 64'd0);
    chk("t6_drv", 64'(nd), 64'd240);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
